// File: rtl/comparator_bist_if.sv
// comparator_bist_if: operand/flag bus between the BIST sequencer and the comparator under test
interface comparator_bist_if;
  logic [5:0] A_out;
  logic [5:0] B_out;
  logic       S_out;
  logic       Equal_in;
  logic       Greater_in;
  logic       Smaller_in;
  modport master (output A_out, B_out, S_out, input Equal_in, Greater_in, Smaller_in);
  modport slave (input A_out, B_out, S_out, output Equal_in, Greater_in, Smaller_in);
endinterface

// File: rtl/comparator_bist.sv
// comparator_bist: exhaustive 6-bit signed/unsigned comparator sweep; CMP_BIST_FAIL_CAPTURE_EN enables the first-failure record
module comparator_bist #(
  parameter int LATENCY = 2
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  input  logic                   start,
  comparator_bist_if.master      cmp,
  output logic                   busy,
  output logic                   done,
  output logic                   pass,
  output logic [7:0]             err_count,
  output logic                   fail_valid,
  output logic [5:0]             fail_A,
  output logic [5:0]             fail_B,
  output logic                   fail_S,
  output logic [2:0]             fail_flags
);
  typedef enum logic [2:0] {IDLE, DRIVE, WAIT, CHECK, DONE} state_t;
  state_t     state;
  logic [5:0] a, b;
  logic       s;
  logic [3:0] cnt;
  logic       go, gt, mismatch, last;
  logic [2:0] rsp, exp_flags;
  logic [7:0] err_nxt;
  assign cmp.A_out = a;
  assign cmp.B_out = b;
  assign cmp.S_out = s;
  always_comb begin
    go        = start && (state == IDLE || state == DONE);
    gt        = s ? ($signed(a) > $signed(b)) : (a > b);
    exp_flags = (a == b) ? 3'b100 : gt ? 3'b010 : 3'b001;
    rsp       = {cmp.Equal_in, cmp.Greater_in, cmp.Smaller_in};
    mismatch  = rsp != exp_flags;
    err_nxt   = (mismatch && err_count != 8'hff) ? err_count + 8'd1 : err_count;
    last      = s && &a && &b;
  end
  // WAIT counts LATENCY down to 0 inclusive, so one vector spans LATENCY+3 cycles
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state     <= IDLE;
      {s, a, b} <= '0;
      cnt       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_count <= '0;
    end else begin
      case (state)
        IDLE, DONE: if (go) begin
          state     <= DRIVE;
          {s, a, b} <= '0;
          err_count <= '0;
          busy      <= 1'b1;
          done      <= 1'b0;
          pass      <= 1'b0;
        end
        DRIVE: begin
          state <= WAIT;
          cnt   <= 4'(LATENCY);
        end
        WAIT: if (cnt == 4'd0) state <= CHECK; else cnt <= cnt - 4'd1;
        CHECK: begin
          err_count <= err_nxt;
          if (last) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= err_nxt == 8'd0;
          end else begin
            state     <= DRIVE;
            {s, a, b} <= {s, a, b} + 13'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
`ifdef CMP_BIST_FAIL_CAPTURE_EN
  always_ff @(posedge CLK) begin
    if (!RST_N || go) begin
      fail_valid <= 1'b0;
      fail_A     <= '0;
      fail_B     <= '0;
      fail_S     <= 1'b0;
      fail_flags <= '0;
    end else if (state == CHECK && mismatch && !fail_valid) begin
      fail_valid <= 1'b1;
      fail_A     <= a;
      fail_B     <= b;
      fail_S     <= s;
      fail_flags <= rsp;
    end
  end
`else
  assign {fail_valid, fail_A, fail_B, fail_S, fail_flags} = '0;
`endif
endmodule

// File: tb/tb_comparator_bist.sv
// tb_comparator_bist: five sequencers swept in parallel against golden, faulty and mistimed comparator responders
module tb_comparator_bist;
  localparam int N = 5;
`ifdef CMP_BIST_FAIL_CAPTURE_EN
  localparam bit CAP = 1'b1;
`else
  localparam bit CAP = 1'b0;
`endif
  function automatic int lat_of(int i);
    return i == 3 ? 1 : i == 4 ? 3 : 2;
  endfunction
  function automatic int depth_of(int i);
    return i >= 3 ? 5 : 4;
  endfunction
  function automatic int mode_of(int i);
    return i == 1 ? 1 : i == 2 ? 2 : 0;
  endfunction
  function automatic logic [2:0] model(logic [5:0] a, logic [5:0] b, logic s, int mode);
    logic gt;
    logic [2:0] f;
    gt = (s && mode != 2) ? ($signed(a) > $signed(b)) : (a > b);
    f = (a == b) ? 3'b100 : gt ? 3'b010 : 3'b001;
    return mode == 1 ? (f & 3'b101) : f;
  endfunction
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic busy [N], done [N], pass [N], fail_valid [N], fail_S [N], op_s [N];
  logic [7:0] err_count [N];
  logic [5:0] fail_A [N], fail_B [N], op_a [N], op_b [N];
  logic [2:0] fail_flags [N];
  int errors = 0, checks = 0;
  always #5 clk = ~clk;
  comparator_bist_if cif [N] ();
  generate
    for (genvar g = 0; g < N; g++) begin : u
      logic [2:0] pl [depth_of(g)];
      comparator_bist #(.LATENCY(lat_of(g))) dut (
        .CLK(clk), .RST_N(rst_n), .start(start), .cmp(cif[g]),
        .busy(busy[g]), .done(done[g]), .pass(pass[g]), .err_count(err_count[g]),
        .fail_valid(fail_valid[g]), .fail_A(fail_A[g]), .fail_B(fail_B[g]),
        .fail_S(fail_S[g]), .fail_flags(fail_flags[g])
      );
      always @(posedge clk) begin
        pl[0] <= model(cif[g].A_out, cif[g].B_out, cif[g].S_out, mode_of(g));
        for (int k = 1; k < depth_of(g); k++) pl[k] <= pl[k-1];
      end
      assign {cif[g].Equal_in, cif[g].Greater_in, cif[g].Smaller_in} = pl[depth_of(g)-1];
      assign op_a[g] = cif[g].A_out;
      assign op_b[g] = cif[g].B_out;
      assign op_s[g] = cif[g].S_out;
    end
  endgenerate
  function automatic logic [40:0] outs(int i);
    return {op_a[i], op_b[i], op_s[i], busy[i], done[i], pass[i], err_count[i],
            fail_valid[i], fail_A[i], fail_B[i], fail_S[i], fail_flags[i]};
  endfunction
  task automatic test_reset();
    repeat (3) @(negedge clk);
    for (int i = 0; i < N; i++) begin
      checks++;
      if (outs(i) !== '0) begin errors++; $display("FAIL reset_state[%0d]: got %h want 0", i, outs(i)); end
    end
    rst_n = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (399) @(negedge clk);
    checks++;
    if (busy[0] !== 1'b1) begin errors++; $display("FAIL mid_busy: got %b want 1", busy[0]); end
    checks++;
    if (err_count[1] !== 8'd1) begin errors++; $display("FAIL mid_err: got %0d want 1", err_count[1]); end
    checks++;
    if (fail_valid[1] !== CAP) begin errors++; $display("FAIL mid_fail_valid: got %b want %b", fail_valid[1], CAP); end
    rst_n = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (outs(i) !== '0) begin errors++; $display("FAIL abort_reset[%0d] cyc%0d: got %h want 0", i, c, outs(i)); end
      end
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask
  task automatic test_sweep();
    int cyc0 = 0, cyc4 = 0, run = 0;
    logic [12:0] cur, prev;
    bit first = 1'b1, poked = 1'b0;
    prev = '0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 60000 && !(done[0] && done[1] && done[2] && done[3] && done[4]); c++) begin
      start = 1'b0;
      if (busy[0]) begin
        cyc0++;
        cur = {op_s[0], op_a[0], op_b[0]};
        if (first) begin
          checks++;
          if (cur !== 13'd0) begin errors++; $display("FAIL first_vector: got %h want 0", cur); end
          first = 1'b0;
          run = 1;
        end else if (cur != prev) begin
          checks++;
          if (cur !== prev + 13'd1 || run != 5) begin
            errors++;
            $display("FAIL sequence: got %h after %h held %0d want %h held 5", cur, prev, run, prev + 13'd1);
          end
          run = 1;
        end else run++;
        prev = cur;
        if (!poked && cur == 13'd100) begin start = 1'b1; poked = 1'b1; end
      end
      if (busy[4]) cyc4++;
      @(negedge clk);
    end
    start = 1'b0;
    checks++;
    if (!(done[0] && done[1] && done[2] && done[3] && done[4])) begin
      errors++;
      $display("FAIL sweep_timeout: got done=%b%b%b%b%b want 11111", done[0], done[1], done[2], done[3], done[4]);
    end
    checks++;
    if (cyc0 != 40960) begin errors++; $display("FAIL busy_cycles_lat2: got %0d want 40960", cyc0); end
    checks++;
    if (cyc4 != 49152) begin errors++; $display("FAIL busy_cycles_lat3: got %0d want 49152", cyc4); end
    checks++;
    if (prev !== 13'h1fff || run != 5) begin errors++; $display("FAIL last_vector: got %h held %0d want 1fff held 5", prev, run); end
    checks++;
    if ({done[0], pass[0], err_count[0], fail_valid[0]} !== {2'b11, 8'd0, 1'b0}) begin
      errors++; $display("FAIL golden: got done/pass/err/fv %b/%b/%0d/%b want 1/1/0/0", done[0], pass[0], err_count[0], fail_valid[0]);
    end
    checks++;
    if ({pass[1], err_count[1]} !== {1'b0, 8'd255}) begin
      errors++; $display("FAIL stuck_greater: got pass/err %b/%0d want 0/255", pass[1], err_count[1]);
    end
    checks++;
    if ({fail_valid[1], fail_A[1], fail_B[1], fail_S[1], fail_flags[1]} !== (CAP ? {1'b1, 6'd1, 6'd0, 1'b0, 3'b000} : 17'd0)) begin
      errors++; $display("FAIL stuck_record: got %b/%0d/%0d/%b/%b", fail_valid[1], fail_A[1], fail_B[1], fail_S[1], fail_flags[1]);
    end
    checks++;
    if ({pass[2], err_count[2]} !== {1'b0, 8'd255}) begin
      errors++; $display("FAIL unsigned_only: got pass/err %b/%0d want 0/255", pass[2], err_count[2]);
    end
    checks++;
    if ({fail_valid[2], fail_A[2], fail_B[2], fail_S[2], fail_flags[2]} !== (CAP ? {1'b1, 6'd0, 6'd32, 1'b1, 3'b001} : 17'd0)) begin
      errors++; $display("FAIL unsigned_record: got %b/%0d/%0d/%b/%b", fail_valid[2], fail_A[2], fail_B[2], fail_S[2], fail_flags[2]);
    end
    checks++;
    if (pass[3] !== 1'b0 || err_count[3] == 8'd0) begin
      errors++; $display("FAIL short_latency: got pass/err %b/%0d want 0/nonzero", pass[3], err_count[3]);
    end
    checks++;
    if ({done[4], pass[4], err_count[4]} !== {2'b11, 8'd0}) begin
      errors++; $display("FAIL latency3: got done/pass/err %b/%b/%0d want 1/1/0", done[4], pass[4], err_count[4]);
    end
  endtask
  task automatic test_hold_done();
    repeat (20) @(negedge clk);
    checks++;
    if ({done[0], pass[0], busy[0]} !== 3'b110) begin
      errors++; $display("FAIL done_hold: got done/pass/busy %b%b%b want 110", done[0], pass[0], busy[0]);
    end
    checks++;
    if ({op_s[0], op_a[0], op_b[0]} !== 13'h1fff) begin
      errors++; $display("FAIL done_operands: got %h want 1fff", {op_s[0], op_a[0], op_b[0]});
    end
  endtask
  task automatic test_restart();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if ({done[1], pass[1], err_count[1], fail_valid[1]} !== 11'd0) begin
      errors++; $display("FAIL restart_clear: got done/pass/err/fv %b/%b/%0d/%b want 0/0/0/0", done[1], pass[1], err_count[1], fail_valid[1]);
    end
    checks++;
    if ({busy[0], done[0], pass[0], op_s[0], op_a[0], op_b[0]} !== {1'b1, 15'd0}) begin
      errors++; $display("FAIL restart_vector: got busy/done/pass %b%b%b vec %h want 100 vec 0", busy[0], done[0], pass[0], {op_s[0], op_a[0], op_b[0]});
    end
    repeat (5) @(negedge clk);
    checks++;
    if ({op_s[0], op_a[0], op_b[0]} !== 13'd1) begin
      errors++; $display("FAIL restart_advance: got %h want 1", {op_s[0], op_a[0], op_b[0]});
    end
  endtask
  initial begin
    test_reset();
    test_sweep();
    test_hold_done();
    test_restart();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
